// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED glyph streamer.
// FSM state encoding, glyph width, default SSD1306 control byte and the
// substitute code rendered for characters outside the font range.
package oled_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CTRL,
        ST_FETCH,
        ST_COL,
        ST_SPACE
    } state_t;

    localparam int         GLYPH_W       = 5;
    localparam logic [7:0] CTRL_BYTE_DEF = 8'h40;
    localparam logic [7:0] SUBST_CHAR    = 8'h3F;

    // Character held for the duration of its glyph
    typedef struct packed {
        logic [7:0] code;
        logic       last;
    } char_req_t;

endpackage

// File: rtl/oled_font_rom.sv
// 5x7 column font for ASCII 0x20..0x7E, one registered read per cycle.
// Address = (char - FIRST_CHAR) * 5 + column. Bit 0 is the top pixel row,
// bit 6 the bottom, bit 7 always clear.
module oled_font_rom
    import oled_pkg::*;
#(
    parameter logic [7:0] FIRST_CHAR = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [8:0] addr,
    output logic [7:0] q
);

    localparam int N_GLYPH = 95;
    localparam int N_BYTES = N_GLYPH * GLYPH_W;
    // Table always starts at 0x20; shift when the font range starts higher
    localparam int BASE    = (int'(FIRST_CHAR) - 32) * GLYPH_W;

    // One 40-bit literal per glyph, column 0 in the top byte
    localparam logic [N_BYTES*8-1:0] FONT = {
        40'h0000000000, 40'h00005F0000, 40'h0007000700, 40'h147F147F14, 40'h242A7F2A12, // 20
        40'h2313086462, 40'h3649552250, 40'h0005030000, 40'h001C224100, 40'h0041221C00, // 25
        40'h082A1C2A08, 40'h08083E0808, 40'h0050300000, 40'h0808080808, 40'h0060600000, // 2A
        40'h2010080402, 40'h3E5149453E, 40'h00427F4000, 40'h4261514946, 40'h2141454B31, // 2F
        40'h1814127F10, 40'h2745454539, 40'h3C4A494930, 40'h0171090503, 40'h3649494936, // 34
        40'h064949291E, 40'h0036360000, 40'h0056360000, 40'h0008142241, 40'h1414141414, // 39
        40'h4122140800, 40'h0201510906, 40'h324979413E, 40'h7E1111117E, 40'h7F49494936, // 3E
        40'h3E41414122, 40'h7F4141221C, 40'h7F49494941, 40'h7F09090101, 40'h3E41415132, // 43
        40'h7F0808087F, 40'h00417F4100, 40'h2040413F01, 40'h7F08142241, 40'h7F40404040, // 48
        40'h7F0204027F, 40'h7F0408107F, 40'h3E4141413E, 40'h7F09090906, 40'h3E4151215E, // 4D
        40'h7F09192946, 40'h4649494931, 40'h01017F0101, 40'h3F4040403F, 40'h1F2040201F, // 52
        40'h7F2018207F, 40'h6314081463, 40'h0304780403, 40'h6151494543, 40'h00007F4141, // 57
        40'h0204081020, 40'h41417F0000, 40'h0402010204, 40'h4040404040, 40'h0001020400, // 5C
        40'h2054545478, 40'h7F48444438, 40'h3844444420, 40'h384444487F, 40'h3854545418, // 61
        40'h087E090102, 40'h081454543C, 40'h7F08040478, 40'h00447D4000, 40'h2040443D00, // 66
        40'h007F102844, 40'h00417F4000, 40'h7C04180478, 40'h7C08040478, 40'h3844444438, // 6B
        40'h7C14141408, 40'h081414187C, 40'h7C08040408, 40'h4854545420, 40'h043F444020, // 70
        40'h3C4040207C, 40'h1C2040201C, 40'h3C4030403C, 40'h4428102844, 40'h0C5050503C, // 75
        40'h4464544C44, 40'h0008364100, 40'h00007F0000, 40'h0041360800, 40'h0804081008  // 7A
    };

    int         idx;
    logic [7:0] rd_byte;

    // Table lookup; addresses past the table read as blank
    always_comb begin
        idx     = int'(addr) + BASE;
        rd_byte = '0;
        if (idx >= 0 && idx < N_BYTES)
            rd_byte = FONT[(N_BYTES-1-idx)*8 +: 8];
    end

    // Output register, updated only when a read is issued
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= '0;
        else if (en)
            q <= rd_byte;
    end

endmodule

// File: rtl/oled_glyph_streamer.sv
// Turns ASCII characters into SSD1306 data bursts: control byte once per
// burst, then five font columns per character. Optional macro
// OLED_GLYPH_SPACER_EN appends a blank 0x00 column after each glyph.
module oled_glyph_streamer
    import oled_pkg::*;
#(
    parameter logic [7:0] FIRST_CHAR = 8'h20,
    parameter logic [7:0] LAST_CHAR  = 8'h7E,
    parameter logic [7:0] CTRL_BYTE  = CTRL_BYTE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_char,
    input  logic       i_last,
    input  logic       i_valid,
    output logic       i_ready,
    output logic [7:0] o_byte,
    output logic       o_start,
    output logic       o_last,
    output logic       o_valid,
    input  logic       o_ready
);

`ifdef OLED_GLYPH_SPACER_EN
    localparam bit SPACER_EN = 1'b1;
`else
    localparam bit SPACER_EN = 1'b0;
`endif
    localparam logic [2:0] COL_LAST = 3'(GLYPH_W - 1);

    state_t     state;
    char_req_t  cur;
    logic       burst_open;
    logic [2:0] col;
    logic       glyph_sel;   // o_byte comes from the ROM register
    logic [7:0] byte_q;      // control byte or spacer
    logic       in_range;
    logic       rom_en;
    logic [2:0] rd_col;
    logic [8:0] rom_addr;
    logic [7:0] rom_q;

    assign in_range = (i_char >= FIRST_CHAR) && (i_char <= LAST_CHAR);

    // Column 0 is read during FETCH; each COL transfer prefetches the next
    // column so the ROM register holds the presented byte through stalls
    always_comb begin
        rom_en = 1'b0;
        rd_col = '0;
        if (state == ST_FETCH) begin
            rom_en = 1'b1;
        end else if (state == ST_COL && o_ready && col != COL_LAST) begin
            rom_en = 1'b1;
            rd_col = col + 3'd1;
        end
        rom_addr = 9'(9'(cur.code - FIRST_CHAR) * 9'(GLYPH_W)) + 9'(rd_col);
    end

    oled_font_rom #(.FIRST_CHAR(FIRST_CHAR)) u_rom (
        .clk  (clk),
        .rst  (rst),
        .en   (rom_en),
        .addr (rom_addr),
        .q    (rom_q)
    );

    assign o_byte = glyph_sel ? rom_q : byte_q;

    // Burst / glyph sequencing FSM with registered handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cur        <= '0;
            burst_open <= 1'b0;
            col        <= '0;
            glyph_sel  <= 1'b0;
            byte_q     <= '0;
            o_valid    <= 1'b0;
            o_start    <= 1'b0;
            o_last     <= 1'b0;
            i_ready    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    i_ready <= 1'b1;
                    if (i_valid && i_ready) begin
                        i_ready  <= 1'b0;
                        cur.code <= in_range ? i_char : SUBST_CHAR;
                        cur.last <= i_last;
                        if (burst_open) begin
                            state <= ST_FETCH;
                        end else begin
                            state   <= ST_CTRL;
                            byte_q  <= CTRL_BYTE;
                            o_start <= 1'b1;
                            o_valid <= 1'b1;
                        end
                    end
                end
                ST_CTRL: begin
                    if (o_ready) begin
                        o_valid    <= 1'b0;
                        o_start    <= 1'b0;
                        burst_open <= 1'b1;
                        state      <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    col       <= '0;
                    glyph_sel <= 1'b1;
                    o_valid   <= 1'b1;
                    o_last    <= 1'b0;
                    state     <= ST_COL;
                end
                ST_COL: begin
                    if (o_ready) begin
                        if (col != COL_LAST) begin
                            col    <= col + 3'd1;
                            o_last <= cur.last && !SPACER_EN && (col == COL_LAST - 3'd1);
                        end else if (SPACER_EN) begin
                            glyph_sel <= 1'b0;
                            byte_q    <= 8'h00;
                            o_last    <= cur.last;
                            state     <= ST_SPACE;
                        end else begin
                            state     <= ST_IDLE;
                            o_valid   <= 1'b0;
                            o_last    <= 1'b0;
                            glyph_sel <= 1'b0;
                            byte_q    <= '0;
                            col       <= '0;
                            i_ready   <= 1'b1;
                            if (cur.last) burst_open <= 1'b0;
                        end
                    end
                end
                ST_SPACE: begin
                    if (o_ready) begin
                        state     <= ST_IDLE;
                        o_valid   <= 1'b0;
                        o_last    <= 1'b0;
                        glyph_sel <= 1'b0;
                        byte_q    <= '0;
                        col       <= '0;
                        i_ready   <= 1'b1;
                        if (cur.last) burst_open <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
